// File: rtl/adder_arb_pkg.sv
// Shared types and default parameters for the adder_arbiter block.
// The optional macro ADDARB_FIXED_PRIO_EN (used by rr_picker and
// adder_arbiter) switches arbitration from round-robin to fixed priority.
package adder_arb_pkg;

    // Default number of requesters sharing the adder.
    localparam int ADDARB_NUM_REQ = 4;

    // Default operand width.
    localparam int ADDARB_DATA_W  = 16;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        STOP  = 2'd2
    } arb_state_t;

endpackage : adder_arb_pkg

// File: rtl/adder_arbiter_rr_picker.sv
// rr_picker: combinational requester selector for adder_arbiter.
// Default build: round-robin search that starts at ptr_i and wraps.
// With ADDARB_FIXED_PRIO_EN defined: the lowest asserted index wins and
// the ptr_i port does not exist.
module rr_picker
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = ADDARB_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
`ifndef ADDARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0]    ptr_i,
`endif
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Walk the candidates in priority order; the first asserted one wins.
    always_comb begin
        logic [ID_W-1:0] cand;
        logic            found;
        logic            hit;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ADDARB_FIXED_PRIO_EN
            cand = ID_W'(i);
`else
            cand = ID_W'((int'(ptr_i) + i) % NUM_REQ);
`endif
            hit           = req_i[cand] & ~found;
            grant_o[cand] = grant_o[cand] | hit;
            idx_o         = hit ? cand : idx_o;
            found         = found | hit;
        end
    end

    assign any_o = |req_i;

endmodule : rr_picker

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one registered adder between NUM_REQ requesters.
// IDLE grants and captures operands, START registers the sum, STOP holds
// the response until the consumer takes it.
// Macro ADDARB_FIXED_PRIO_EN selects fixed-priority arbitration (no ptr);
// the default build uses round-robin.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = ADDARB_NUM_REQ,
    parameter  int DATA_W  = ADDARB_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W:0]           rsp_sum,
    input  logic                      rsp_ready
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   gid_q, gid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W:0]   rsp_sum_q, rsp_sum_d;
`ifndef ADDARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   ptr_q, ptr_d;
`endif

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [ID_W-1:0]    pick_idx_s;
    logic               pick_any_s;
    logic [DATA_W-1:0]  a_arr_s [NUM_REQ];
    logic [DATA_W-1:0]  b_arr_s [NUM_REQ];

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr_s[gi] = req_a[gi*DATA_W +: DATA_W];
        assign b_arr_s[gi] = req_b[gi*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_valid),
`ifndef ADDARB_FIXED_PRIO_EN
        .ptr_i   (ptr_q),
`endif
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Accept strobe only while idle and out of reset, so it is zero in reset.
    always_comb begin
        if ((state_q == IDLE) && rst_n) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state, operand capture and response generation.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        gid_d       = gid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
`ifndef ADDARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    a_d     = a_arr_s[pick_idx_s];
                    b_d     = b_arr_s[pick_idx_s];
                    gid_d   = pick_idx_s;
                    state_d = START;
`ifndef ADDARB_FIXED_PRIO_EN
                    if (pick_idx_s == ID_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick_idx_s + ID_W'(1);
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                rsp_sum_d   = {1'b0, a_q} + {1'b0, b_q};
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = STOP;
            end
            STOP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = STOP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset discards any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            gid_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
`ifndef ADDARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gid_q       <= gid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
`ifndef ADDARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (NUM_REQ=4, DATA_W=16).
// Honours ADDARB_FIXED_PRIO_EN for the expected grant order.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [16:0] rsp_sum;
    logic        rsp_ready;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  keep;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  exp_id;
        logic [16:0] exp_sum;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [16:0] sum;
    } exp_t;

    vec_t tbl [11];
    vec_t rm_vec;
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    adder_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: a response is consumed at the next edge when valid && ready.
    task automatic mon();
        exp_t e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: actual id=%0d sum=0x%0h required no response", rsp_id, rsp_sum);
            end else begin
                e = sb_q.pop_front();
                chk("sb_id", 32'(rsp_id), 32'(e.id));
                chk("sb_sum", 32'(rsp_sum), 32'(e.sum));
            end
        end
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 20) begin
            cycle();
            n++;
        end
        chk({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << v.exp_id));
        sb_q.push_back('{id: v.exp_id, sum: v.exp_sum});
        cycle();
        req_valid = v.keep;
        chk({tag, "_start_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_start_valid"}, 32'(rsp_valid), 32'h0);
        cycle();
        chk({tag, "_t2_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_t2_id"}, 32'(rsp_id), 32'(v.exp_id));
        chk({tag, "_t2_sum"}, 32'(rsp_sum), 32'(v.exp_sum));
        cycle();
        chk({tag, "_t3_valid"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        // Isolated requests (ptr starts at 0): single, carry, wrap, late drop.
        tbl[0] = '{4'b0100, 4'b0000, 64'h0000_0005_0000_0000, 64'h0000_0003_0000_0000, 2'd2, 17'h00008};
        tbl[1] = '{4'b0010, 4'b0000, 64'h0000_0000_FFFF_0000, 64'h0000_0000_FFFF_0000, 2'd1, 17'h1FFFE};
`ifdef ADDARB_FIXED_PRIO_EN
        tbl[2] = '{4'b1001, 4'b0000, 64'h0A00_0000_0000_0100, 64'h00B0_0000_0000_0010, 2'd0, 17'h00110};
`else
        tbl[2] = '{4'b1001, 4'b0000, 64'h0A00_0000_0000_0100, 64'h00B0_0000_0000_0010, 2'd3, 17'h00AB0};
`endif
        tbl[3] = '{4'b1001, 4'b0000, 64'h0A00_0000_0000_0100, 64'h00B0_0000_0000_0010, 2'd0, 17'h00110};
        tbl[4] = '{4'b0010, 4'b0000, 64'h0000_0000_1234_0000, 64'h0000_0000_4321_0000, 2'd1, 17'h05555};
        // All four held valid from reset.
`ifdef ADDARB_FIXED_PRIO_EN
        tbl[5]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[6]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[7]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[8]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[9]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[10] = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
`else
        tbl[5]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[6]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd1, 17'h02002};
        tbl[7]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd2, 17'h03003};
        tbl[8]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd3, 17'h04004};
        tbl[9]  = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd0, 17'h01001};
        tbl[10] = '{4'b1111, 4'b1111, 64'h4000_3000_2000_1000, 64'h0004_0003_0002_0001, 2'd1, 17'h02002};
`endif
        rm_vec = '{4'b0101, 4'b0000, 64'h0000_0000_00AA_0011, 64'h0000_0000_0055_0022, 2'd0, 17'h00033};

        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset with all requesters valid, then release into continuous traffic.
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy_ready", 32'(req_ready), 32'h0);
        cycle();
        rst_n = 1'b1;
        for (int i = 5; i < 11; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        req_valid = 4'b0000;
        cycle();

        // Backpressure: response held for 5 cycles, waiting request never accepted.
        req_a     = 64'h0000_1234_0000_0007;
        req_b     = 64'h0000_0101_0000_0009;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h4);
        sb_q.push_back('{id: 2'd2, sum: 17'h01335});
        cycle();
        req_valid = 4'b0001;
        chk("bp_start_ready", 32'(req_ready), 32'h0);
        cycle();
        chk("bp_t2_valid", 32'(rsp_valid), 32'h1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_hold%0d_id", k), 32'(rsp_id), 32'h2);
            chk($sformatf("bp_hold%0d_sum", k), 32'(rsp_sum), 32'h1335);
            chk($sformatf("bp_hold%0d_ready", k), 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_idle_grant", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        cycle();

        // Reset asserted during START: transaction discarded, ptr back to 0.
        req_a     = 64'h0000_0000_00AA_0011;
        req_b     = 64'h0000_0000_0055_0022;
        req_valid = 4'b0010;
        #1;
        chk("rm_grant", 32'(req_ready), 32'h2);
        cycle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rm_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rm_rsp_id", 32'(rsp_id), 32'h0);
        chk("rm_rsp_sum", 32'(rsp_sum), 32'h0);
        chk("rm_req_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0101;
        cycle();
        cycle();
        rst_n = 1'b1;
        run_vec(rm_vec, "rm_next");

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_arbiter
